// File: rtl/ntt_bitrev_reorder.sv
// ntt_bitrev_reorder: converts a bit-reversed NTT frame stream back to natural order
// using a ping-pong pair of N-word banks. One bank fills while the other drains.
// Optional build macro NTT_REORDER_ERR_EN enables the frame_err pulse on a
// mid-frame in_start; without it frame_err is tied low (abort behaviour is the same).
// rst_n is a synchronous, active-HIGH reset despite its name.
module ntt_bitrev_reorder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_start,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int N = 1 << ADDR_WIDTH;

  typedef enum logic { W_IDLE, W_FILL }   wstate_e;
  typedef enum logic { R_IDLE, R_ACTIVE } rstate_e;

  function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      r[i] = a[ADDR_WIDTH-1-i];
    end
    return r;
  endfunction

  // Both banks in one array; the MSB of the address selects the bank.
  logic [DATA_WIDTH-1:0] mem [0:2*N-1];

  wstate_e               wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic                  wbank_q, wbank_d;
  rstate_e               rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  rbank_q, rbank_d;

  logic                  out_valid_q;
  logic                  out_last_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  frame_done;
  logic                  rd_en;

  // in_start always carries sample 0, so it restarts the index even mid-frame
  // (abort) and the write happens in the same cycle as the pulse.
  always_comb begin
    wr_idx     = in_start ? '0 : wcnt_q;
    wr_en      = in_start || (wstate_q == W_FILL);
    frame_done = wr_en && (&wr_idx);
    rd_en      = (rstate_q == R_ACTIVE);
  end

  // Write FSM next state: count samples, flip banks only on a completed frame.
  always_comb begin
    wstate_d = wstate_q;
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    if (wr_en) begin
      if (frame_done) begin
        wstate_d = W_IDLE;
        wcnt_d   = '0;
        wbank_d  = ~wbank_q;
      end else begin
        wstate_d = W_FILL;
        wcnt_d   = wr_idx + 1'b1;
      end
    end
  end

  // Read FSM next state: a completed frame (re)starts the drain at address 0,
  // which also covers back-to-back frames landing on the final read address.
  always_comb begin
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    rbank_d  = rbank_q;
    if (frame_done) begin
      rstate_d = R_ACTIVE;
      raddr_d  = '0;
      rbank_d  = wbank_q;
    end else if (rstate_q == R_ACTIVE) begin
      if (&raddr_q) begin
        rstate_d = R_IDLE;
        raddr_d  = '0;
      end else begin
        raddr_d  = raddr_q + 1'b1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wstate_q <= W_IDLE;
      wcnt_q   <= '0;
      wbank_q  <= 1'b0;
      rstate_q <= R_IDLE;
      raddr_q  <= '0;
      rbank_q  <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wcnt_q   <= wcnt_d;
      wbank_q  <= wbank_d;
      rstate_q <= rstate_d;
      raddr_q  <= raddr_d;
      rbank_q  <= rbank_d;
    end
  end

  // Scatter write into the fill bank; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en && !rst_n) begin
      mem[{wbank_q, bitrev(wr_idx)}] <= in_data;
    end
  end

  // Registered synchronous read doubles as the output register; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (rd_en) begin
      out_valid_q <= 1'b1;
      out_last_q  <= &raddr_q;
      out_data_q  <= mem[{rbank_q, raddr_q}];
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = (wstate_q == W_FILL) || (rstate_q == R_ACTIVE) || out_valid_q;

`ifdef NTT_REORDER_ERR_EN
  assign frame_err = !rst_n && in_start && (wstate_q == W_FILL) && (wcnt_q != '0);
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Self-checking bench for ntt_bitrev_reorder (default DATA_WIDTH=64, ADDR_WIDTH=4).
module tb_ntt_bitrev_reorder;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int N  = 16;
  localparam int MAXC = 8192;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_start;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          frame_err;

  ntt_bitrev_reorder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", nm, cyc, act, expv);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    int v = x;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  // Behavioural model: expected output schedule indexed by absolute cycle.
  bit            exp_v [MAXC];
  bit            exp_l [MAXC];
  logic [DW-1:0] exp_d [MAXC];
  logic [DW-1:0] frm [N];
  logic [DW-1:0] held = '0;
  bit            capturing = 0;
  int            cnt = 0;
  int            start_c = 0;

  // Recorded DUT activity for directed checks.
  logic [DW-1:0] rec_d[$];
  int            rec_c[$];
  bit            rec_l[$];
  int            err_c[$];

  always @(negedge clk) begin : compare
    int c;
    bit e_err, e_busy, ev;
    logic [DW-1:0] ed;
    c = cyc;
    ev = exp_v[c];
    ed = ev ? exp_d[c] : held;
`ifdef NTT_REORDER_ERR_EN
    e_err = !rst_n && in_start && capturing;
`else
    e_err = 1'b0;
`endif
    e_busy = capturing || exp_v[c] || exp_v[c+1];
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data", out_data, ed);
    chk("out_last", 64'(out_last), 64'(ev && exp_l[c]));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("frame_err", 64'(frame_err), 64'(e_err));
    held = ed;
    if (out_valid) begin
      rec_d.push_back(out_data);
      rec_c.push_back(c);
      rec_l.push_back(out_last);
    end
    if (frame_err) err_c.push_back(c);
    // advance model with this cycle's inputs
    if (rst_n) begin
      capturing = 0;
      cnt = 0;
      for (int k = c + 1; k < c + 3 * N && k < MAXC; k++) exp_v[k] = 0;
      held = '0;
    end else if (in_start) begin
      capturing = 1;
      frm[0] = in_data;
      cnt = 1;
      start_c = c;
    end else if (capturing) begin
      frm[cnt] = in_data;
      cnt++;
      if (cnt == N) begin
        for (int n = 0; n < N; n++) begin
          exp_v[start_c + N + 1 + n] = 1;
          exp_d[start_c + N + 1 + n] = frm[brev(n)];
          exp_l[start_c + N + 1 + n] = (n == N - 1);
        end
        capturing = 0;
      end
    end
  end

  task automatic step(input bit s, input logic [DW-1:0] d, input bit r);
    @(posedge clk);
    #1;
    in_start = s;
    in_data  = d;
    rst_n    = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0);
  endtask

  task automatic clear_rec();
    rec_d.delete();
    rec_c.delete();
    rec_l.delete();
    err_c.delete();
  endtask

  task automatic send_frame(input logic [DW-1:0] base, output int t);
    step(1, base, 0);
    t = cyc;
    for (int j = 1; j < N; j++) step(0, base + DW'(j), 0);
  endtask

  logic [DW-1:0] lit [N];
  int t0, t1;

  initial begin
    rst_n = 1; in_start = 0; in_data = '0;
    lit = '{64'd100, 64'd108, 64'd104, 64'd112, 64'd102, 64'd110, 64'd106, 64'd114,
            64'd101, 64'd109, 64'd105, 64'd113, 64'd103, 64'd111, 64'd107, 64'd115};
    repeat (3) step(0, '0, 1);
    idle(3);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_data", out_data, 64'd0);

    // Single frame, literal expectations.
    clear_rec();
    send_frame(64'd100, t0);
    idle(20);
    chk("s1_count", 64'(rec_d.size()), 64'd16);
    if (rec_d.size() == 16) begin
      chk("s1_first_cyc", 64'(rec_c[0]), 64'(t0 + 17));
      chk("s1_last_cyc", 64'(rec_c[15]), 64'(t0 + 32));
      chk("s1_last_flag", 64'(rec_l[15]), 64'd1);
      for (int n = 0; n < N; n++) chk("s1_data", rec_d[n], lit[n]);
    end

    // Back-to-back frames.
    clear_rec();
    send_frame(64'd200, t0);
    send_frame(64'd300, t1);
    idle(22);
    chk("s2_count", 64'(rec_d.size()), 64'd32);
    chk("s2_t1", 64'(t1), 64'(t0 + 16));
    if (rec_d.size() == 32) begin
      chk("s2_contig", 64'(rec_c[31] - rec_c[0]), 64'd31);
      chk("s2_last0", 64'(rec_c[15]), 64'(t0 + 32));
      chk("s2_last1", 64'(rec_c[31]), 64'(t0 + 48));
      chk("s2_f2_d0", rec_d[16], 64'd300);
      chk("s2_f1_d1", rec_d[1], 64'd208);
    end

    // Mid-frame restart at T+5.
    clear_rec();
    step(1, 64'd400, 0);
    t0 = cyc;
    for (int j = 1; j < 5; j++) step(0, 64'd400 + DW'(j), 0);
    send_frame(64'd500, t1);
    idle(22);
    chk("s3_count", 64'(rec_d.size()), 64'd16);
    if (rec_d.size() == 16) begin
      chk("s3_first_cyc", 64'(rec_c[0]), 64'(t0 + 22));
      chk("s3_d0", rec_d[0], 64'd500);
      chk("s3_d1", rec_d[1], 64'd508);
    end
`ifdef NTT_REORDER_ERR_EN
    chk("s3_err_count", 64'(err_c.size()), 64'd1);
    if (err_c.size() == 1) chk("s3_err_cyc", 64'(err_c[0]), 64'(t0 + 5));
`else
    chk("s3_err_count", 64'(err_c.size()), 64'd0);
`endif

    // Reset during output at T+20.
    clear_rec();
    send_frame(64'd600, t0);
    idle(4);
    step(0, '0, 1);
    idle(30);
    chk("s4_count", 64'(rec_d.size()), 64'd4);
    if (rec_d.size() == 4) chk("s4_last_cyc", 64'(rec_c[3]), 64'(t0 + 20));
    chk("s4_busy", 64'(busy), 64'd0);

    // All-ones frame, full width.
    clear_rec();
    step(1, '1, 0);
    for (int j = 1; j < N; j++) step(0, '1, 0);
    idle(20);
    chk("s5_count", 64'(rec_d.size()), 64'd16);
    for (int n = 0; n < rec_d.size(); n++) chk("s5_ones", rec_d[n], '1);

    // Randomized frames with gaps, back-to-back runs and aborts.
    for (int f = 0; f < 30; f++) begin
      int gap;
      gap = $urandom_range(0, 3);
      idle(gap);
      if ($urandom_range(0, 5) == 0) begin
        int p;
        p = $urandom_range(1, N - 1);
        step(1, {$urandom(), $urandom()}, 0);
        for (int j = 1; j < p; j++) step(0, {$urandom(), $urandom()}, 0);
      end
      step(1, {$urandom(), $urandom()}, 0);
      for (int j = 1; j < N; j++) step(0, {$urandom(), $urandom()}, 0);
    end
    idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
